// File: rtl/tail_light_ctrl_if.sv
// Switch/timer/lamp bundle for the tail-light sequencer.
// The master side drives requests and ticks; the slave side returns clear, lamps and status.
interface tail_light_ctrl_if #(
  parameter int SEQ_W = 8
);
  logic             left;
  logic             right;
  logic             haz;
  logic             tick;
  logic             timer_clear;
  logic [5:0]       lights;
  logic             active;
  logic [SEQ_W-1:0] seq_count;

  modport master (
    output left, right, haz, tick,
    input  timer_clear, lights, active, seq_count
  );

  modport slave (
    input  left, right, haz, tick,
    output timer_clear, lights, active, seq_count
  );
endinterface

// File: rtl/tail_light_ctrl.sv
// Thunderbird tail-light sequencer: lamps/active/seq_count update one clk after the decision cycle.
// No backpressure; timer_clear is a same-cycle Mealy output to restart the step timer.
module tail_light_ctrl #(
  parameter bit GAP_EN = 1'b1,
  parameter int SEQ_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  tail_light_ctrl_if.slave  bus
);

  typedef enum logic [3:0] {
    IDLE, L1, L2, L3, R1, R2, R3, LR3, GAP
  } state_t;

  state_t           state, state_nx;
  logic [5:0]       lights_q, lights_nx;
  logic             active_q;
  logic [SEQ_W-1:0] seq_q;
  logic             seq_inc;
  logic             hz, lf, rt;
  logic             in_seq;

  assign hz = bus.haz | (bus.left & bus.right);
  assign lf = bus.left & ~hz;
  assign rt = bus.right & ~hz;

  // Only the directional patterns can be preempted; LR3 and GAP ignore hz.
  assign in_seq = (state == L1) || (state == L2) || (state == L3) ||
                  (state == R1) || (state == R2) || (state == R3);

  always_comb begin
    state_nx        = state;
    seq_inc         = 1'b0;
    bus.timer_clear = reset;
    case (state)
      IDLE: begin
        if (hz) begin
          state_nx        = LR3;
          bus.timer_clear = 1'b1;
        end else if (lf) begin
          state_nx        = L1;
          bus.timer_clear = 1'b1;
        end else if (rt) begin
          state_nx        = R1;
          bus.timer_clear = 1'b1;
        end
      end
      L1:  if (bus.tick) state_nx = L2;
      L2:  if (bus.tick) state_nx = L3;
      R1:  if (bus.tick) state_nx = R2;
      R2:  if (bus.tick) state_nx = R3;
      L3, R3, LR3: begin
        if (bus.tick) begin
          if (GAP_EN) begin
            state_nx = GAP;
          end else begin
            state_nx = IDLE;
            seq_inc  = 1'b1;
          end
        end
      end
      GAP: begin
        if (bus.tick) begin
          state_nx = IDLE;
          seq_inc  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    // Preemption overrides any tick-driven step in the same cycle.
    if (in_seq && hz) begin
      state_nx        = LR3;
      seq_inc         = 1'b0;
      bus.timer_clear = 1'b1;
    end
  end

  always_comb begin
    lights_nx = 6'b000000;
    case (state_nx)
      L1:      lights_nx = 6'b001000;
      L2:      lights_nx = 6'b011000;
      L3:      lights_nx = 6'b111000;
      R1:      lights_nx = 6'b000100;
      R2:      lights_nx = 6'b000110;
      R3:      lights_nx = 6'b000111;
      LR3:     lights_nx = 6'b111111;
      default: lights_nx = 6'b000000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      lights_q <= 6'b000000;
      active_q <= 1'b0;
      seq_q    <= '0;
    end else begin
      state    <= state_nx;
      lights_q <= lights_nx;
      active_q <= (state_nx != IDLE);
      if (seq_inc) seq_q <= seq_q + 1'b1;
    end
  end

  assign bus.lights    = lights_q;
  assign bus.active    = active_q;
  assign bus.seq_count = seq_q;

endmodule

// File: tb/tb_tail_light_ctrl.sv
// Random request/tick stimulus on a GAP_EN=1 and a GAP_EN=0 instance, scored against a pattern/step model.
module tb_tail_light_ctrl;

  logic clk;
  logic reset;

  tail_light_ctrl_if #(.SEQ_W(8)) bus0 ();
  tail_light_ctrl_if #(.SEQ_W(8)) bus1 ();

  tail_light_ctrl #(.GAP_EN(1'b1), .SEQ_W(8)) u_gap (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0.slave)
  );

  tail_light_ctrl #(.GAP_EN(1'b0), .SEQ_W(8)) u_nogap (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: pattern kind (0 none, 1 left, 2 right, 3 hazard) plus step position.
  // Left/right use positions 0..2 for lamp steps and 3 for the gap; hazard uses 0 and 1.
  int mode [2];
  int pos  [2];
  int seqn [2];
  int wraps_seen;

  logic l_in, r_in, h_in, t_in;

  function automatic logic [5:0] lamp(input int m, input int p);
    case (m)
      1: return (p <= 2) ? 6'(((1 << (p + 1)) - 1) << 3) : 6'd0;
      2: return (p <= 2) ? 6'((7 << (2 - p)) & 7) : 6'd0;
      3: return (p == 0) ? 6'd63 : 6'd0;
      default: return 6'd0;
    endcase
  endfunction

  function automatic bit hz_now();
    return h_in | (l_in & r_in);
  endfunction

  function automatic bit exp_clear(input int d);
    if (reset) return 1'b1;
    if (mode[d] == 0) return hz_now() | l_in | r_in;
    if ((mode[d] == 1 || mode[d] == 2) && pos[d] <= 2 && hz_now()) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step(input int d);
    int  last;
    bit  gap_en;
    gap_en = (d == 0);
    if (reset) begin
      mode[d] = 0; pos[d] = 0; seqn[d] = 0;
    end else if (mode[d] == 0) begin
      pos[d] = 0;
      if (hz_now())  mode[d] = 3;
      else if (l_in) mode[d] = 1;
      else if (r_in) mode[d] = 2;
    end else if ((mode[d] == 1 || mode[d] == 2) && pos[d] <= 2 && hz_now()) begin
      mode[d] = 3; pos[d] = 0;
    end else if (t_in) begin
      last = (mode[d] == 3) ? 0 : 2;
      if (pos[d] < last) begin
        pos[d]++;
      end else if (pos[d] == last && gap_en) begin
        pos[d]++;
      end else begin
        mode[d] = 0; pos[d] = 0;
        if (seqn[d] == 255) wraps_seen++;
        seqn[d] = (seqn[d] + 1) % 256;
      end
    end
  endtask

  task automatic drive(input logic rs, input logic l, input logic r, input logic h, input logic t);
    reset = rs; l_in = l; r_in = r; h_in = h; t_in = t;
    bus0.left = l; bus0.right = r; bus0.haz = h; bus0.tick = t;
    bus1.left = l; bus1.right = r; bus1.haz = h; bus1.tick = t;
  endtask

  task automatic run_cycle(input logic rs, input logic l, input logic r, input logic h, input logic t);
    @(negedge clk);
    check_val("gap.lights",   32'(bus0.lights),    32'(lamp(mode[0], pos[0])));
    check_val("gap.active",   32'(bus0.active),    32'(mode[0] != 0));
    check_val("gap.seq",      32'(bus0.seq_count), 32'(seqn[0]));
    check_val("nogap.lights", 32'(bus1.lights),    32'(lamp(mode[1], pos[1])));
    check_val("nogap.active", 32'(bus1.active),    32'(mode[1] != 0));
    check_val("nogap.seq",    32'(bus1.seq_count), 32'(seqn[1]));
    drive(rs, l, r, h, t);
    #1;
    check_val("gap.clear",    32'(bus0.timer_clear), 32'(exp_clear(0)));
    check_val("nogap.clear",  32'(bus1.timer_clear), 32'(exp_clear(1)));
    model_step(0);
    model_step(1);
  endtask

  initial begin
    int  hold;
    logic [2:0] req;
    wraps_seen = 0;
    for (int d = 0; d < 2; d++) begin
      mode[d] = 0; pos[d] = 0; seqn[d] = 0;
    end
    hold = 0;
    req  = 3'b000;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);

    // Left held with a tick every fifth cycle, then a right request released early.
    for (int i = 0; i < 30; i++) run_cycle(1'b0, 1'b1, 1'b0, 1'b0, (i % 5) == 4);
    for (int i = 0; i < 2; i++)  run_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 25; i++) run_cycle(1'b0, 1'b0, 1'b0, 1'b0, (i % 5) == 4);

    // Random requests held for random spans, sparse ticks, occasional hazard and reset.
    for (int i = 0; i < 4000; i++) begin
      if (hold == 0) begin
        req[0] = ($urandom_range(0, 2) == 0);
        req[1] = ($urandom_range(0, 2) == 0);
        req[2] = ($urandom_range(0, 5) == 0);
        hold   = $urandom_range(1, 14);
      end else begin
        hold--;
      end
      run_cycle($urandom_range(0, 199) == 0, req[0], req[1], req[2],
                $urandom_range(0, 3) == 0);
    end

    // Continuous left with a tick every cycle drives both counters through their wrap.
    for (int i = 0; i < 2100; i++) run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check_val("wrap.seen", 32'(wraps_seen > 0), 32'd1);

    // Reset in the middle of a right pattern.
    for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b0, 1'b1, 1'b0, i == 2);
    run_cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
